// File: rtl/nf_alu_pkg.sv
// Shared decode constants, ALU command patterns and E-stage record for the
// nf_alu_issue decode/issue/writeback front end.
package nf_alu_pkg;

  localparam int NF_XLEN = 32;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_OR  = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;

  // Command word keeps funct7/funct3/opcode and drops the register/shamt fields.
  localparam logic [31:0] CMD_FIELD_MASK = 32'hFE00_707F;

  localparam logic [31:0] CMD_ADD  = {F7_BASE, 10'd0, F3_ADD, 5'd0, OPC_OP};
  localparam logic [31:0] CMD_OR   = {F7_BASE, 10'd0, F3_OR,  5'd0, OPC_OP};
  localparam logic [31:0] CMD_SLLI = {F7_BASE, 10'd0, F3_SLL, 5'd0, OPC_OPIMM};

  typedef enum logic [2:0] {
    OP_LUI,
    OP_ADD,
    OP_SLLI,
    OP_OR,
    OP_ILL
  } op_e;

  typedef struct packed {
    logic                 valid;
    logic [4:0]           rd;
    logic [NF_XLEN-1:0]   srca;
    logic [NF_XLEN-1:0]   srcb;
    logic [4:0]           shamt;
    logic [31:0]          opcode;
  } estage_t;

  function automatic logic [31:0] alu_cmd(input logic [31:0] instr);
    return instr & CMD_FIELD_MASK;
  endfunction

  function automatic op_e decode_op(input logic [31:0] instr);
    op_e op;
    op = OP_ILL;
    if (instr[6:0] == OPC_LUI)
      op = OP_LUI;
    else if (alu_cmd(instr) == CMD_ADD)
      op = OP_ADD;
    else if (alu_cmd(instr) == CMD_OR)
      op = OP_OR;
    else if (alu_cmd(instr) == CMD_SLLI)
      op = OP_SLLI;
    return op;
  endfunction

endpackage

// File: rtl/nf_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, whole array cleared on reset.
module nf_reg_file #(
  parameter int XLEN     = 32,
  parameter int RF_DEPTH = 32,
  localparam int AW      = $clog2(RF_DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [RF_DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RF_DEPTH; i++)
        regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/nf_alu_issue.sv
// Decode/issue/writeback front end for the combinational ALU: decodes LUI,
// ADD, SLLI and OR, forwards from the execute stage and retires into the RF.
module nf_alu_issue
  import nf_alu_pkg::*;
#(
  parameter int XLEN     = NF_XLEN,
  parameter int RF_DEPTH = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     instr,
  input  logic            instr_vld,
  output logic            instr_rdy,
  input  logic            stall,
  output logic [XLEN-1:0] alu_srcA,
  output logic [XLEN-1:0] alu_srcB,
  output logic [4:0]      alu_shamt,
  output logic [31:0]     alu_opcode,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic [31:0]     retired
);

  logic            accept_p0;
  logic            legal_p0;
  op_e             op_p0;
  logic [4:0]      rs1_p0;
  logic [4:0]      rs2_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] rs1val_p0;
  logic [XLEN-1:0] rs2val_p0;
  logic [XLEN-1:0] srcb_p0;
  logic [4:0]      shamt_p0;

  estage_t         e_p1;
  logic            illegal_p1;
  logic [31:0]     retired_p1;
  logic            zero_p1;
  logic            status_unused;

  // ---- D stage: handshake, decode, operand read with forwarding ----
  assign instr_rdy = ~stall;
  assign accept_p0 = instr_vld & ~stall;
  assign op_p0     = decode_op(instr);
  assign legal_p0  = (op_p0 != OP_ILL);
  assign rs1_p0    = instr[19:15];
  assign rs2_p0    = instr[24:20];
  assign rd_p0     = instr[11:7];

  nf_reg_file #(
    .XLEN     (XLEN),
    .RF_DEPTH (RF_DEPTH)
  ) u_rf (
    .clk    (clk),
    .resetn (resetn),
    .ra1    (rs1_p0),
    .ra2    (rs2_p0),
    .rd1    (rf_rd1),
    .rd2    (rf_rd2),
    .we     (wb_we),
    .wa     (e_p1.rd),
    .wd     (alu_result)
  );

  // The op in E writes the RF at the same edge this instruction is accepted,
  // so its result must be taken straight from the ALU.
  always_comb begin
    rs1val_p0 = rf_rd1;
    rs2val_p0 = rf_rd2;
    if (e_p1.valid && (e_p1.rd == rs1_p0) && (rs1_p0 != '0))
      rs1val_p0 = alu_result;
    if (e_p1.valid && (e_p1.rd == rs2_p0) && (rs2_p0 != '0))
      rs2val_p0 = alu_result;
  end

  always_comb begin
    srcb_p0  = '0;
    shamt_p0 = '0;
    case (op_p0)
      OP_LUI:  srcb_p0  = {{(XLEN-20){1'b0}}, instr[31:12]};
      OP_ADD:  srcb_p0  = rs2val_p0;
      OP_OR:   srcb_p0  = rs2val_p0;
      OP_SLLI: shamt_p0 = instr[24:20];
      default: srcb_p0  = '0;
    endcase
  end

  // ---- E stage register: issue to ALU, illegal pulse, retire counter ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_p1 <= '0;
    end else if (!stall) begin
      e_p1.valid <= accept_p0 & legal_p0;
      if (accept_p0 && legal_p0) begin
        e_p1.rd     <= rd_p0;
        e_p1.srca   <= rs1val_p0;
        e_p1.srcb   <= srcb_p0;
        e_p1.shamt  <= shamt_p0;
        e_p1.opcode <= alu_cmd(instr);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      illegal_p1 <= 1'b0;
      retired_p1 <= '0;
      zero_p1    <= 1'b0;
    end else begin
      illegal_p1 <= accept_p0 & ~legal_p0;
      if (e_p1.valid && !stall) begin
        retired_p1 <= retired_p1 + 32'd1;
        zero_p1    <= alu_zero;
      end
    end
  end

  // ALU zero flag is kept as E-side status only; nothing consumes it yet.
  assign status_unused = zero_p1;

  // ---- writeback / outputs ----
  assign alu_srcA   = e_p1.srca;
  assign alu_srcB   = e_p1.srcb;
  assign alu_shamt  = e_p1.shamt;
  assign alu_opcode = e_p1.opcode;
  assign wb_we      = e_p1.valid & (e_p1.rd != '0) & ~stall;
  assign wb_addr    = e_p1.rd;
  assign wb_data    = alu_result;
  assign illegal    = illegal_p1;
  assign retired    = retired_p1;

endmodule

// File: tb/tb_nf_alu_issue.sv
// Bench for nf_alu_issue: directed vector table, stall/reset sequence, then
// randomized traffic against an ISA-level reference model.
module tb_nf_alu_issue;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] instr;
  logic        instr_vld;
  logic        instr_rdy;
  logic        stall;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_opcode;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;

  nf_alu_issue dut (
    .clk        (clk),
    .resetn     (resetn),
    .instr      (instr),
    .instr_vld  (instr_vld),
    .instr_rdy  (instr_rdy),
    .stall      (stall),
    .alu_srcA   (alu_srcA),
    .alu_srcB   (alu_srcB),
    .alu_shamt  (alu_shamt),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Behavioural ALU driven by the issued command word.
  always_comb begin
    alu_result = 32'd0;
    if (alu_opcode[6:0] == 7'b0110111)
      alu_result = alu_srcB << 12;
    else if (alu_opcode[6:0] == 7'b0110011 && alu_opcode[14:12] == 3'b000)
      alu_result = alu_srcA + alu_srcB;
    else if (alu_opcode[6:0] == 7'b0110011 && alu_opcode[14:12] == 3'b110)
      alu_result = alu_srcA | alu_srcB;
    else if (alu_opcode[6:0] == 7'b0010011 && alu_opcode[14:12] == 3'b001)
      alu_result = alu_srcA << alu_shamt;
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (ISA-level) ----------------
  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] srca, srcb, opc, result;
    logic [4:0]  shamt;
  } pend_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_ret;
  logic        m_ill;
  pend_t       pend;

  // 0=LUI 1=ADD 2=SLLI 3=OR 4=illegal
  function automatic int classify(input logic [31:0] w);
    if (w[6:0] == 7'b0110111) return 0;
    if (w[31:25] == 7'd0 && w[6:0] == 7'b0110011 && w[14:12] == 3'd0) return 1;
    if (w[31:25] == 7'd0 && w[6:0] == 7'b0010011 && w[14:12] == 3'd1) return 2;
    if (w[31:25] == 7'd0 && w[6:0] == 7'b0110011 && w[14:12] == 3'd6) return 3;
    return 4;
  endfunction

  task automatic model_edge(input logic v, input logic s, input logic [31:0] w);
    logic [31:0] a, b;
    int k;
    if (s) begin
      m_ill = 1'b0;
      return;
    end
    if (pend.valid) begin
      m_ret = m_ret + 32'd1;
      if (pend.rd != 5'd0) m_regs[pend.rd] = pend.result;
    end
    pend.valid = 1'b0;
    m_ill = 1'b0;
    if (!v) return;
    k = classify(w);
    if (k == 4) begin
      m_ill = 1'b1;
      return;
    end
    a = m_regs[w[19:15]];
    b = m_regs[w[24:20]];
    pend.valid = 1'b1;
    pend.rd    = w[11:7];
    pend.srca  = a;
    pend.opc   = {w[31:25], 10'd0, w[14:12], 5'd0, w[6:0]};
    pend.shamt = 5'd0;
    case (k)
      0: begin pend.srcb = {12'd0, w[31:12]}; pend.result = {w[31:12], 12'd0}; end
      1: begin pend.srcb = b; pend.result = a + b; end
      2: begin pend.srcb = 32'd0; pend.shamt = w[24:20]; pend.result = a << w[24:20]; end
      default: begin pend.srcb = b; pend.result = a | b; end
    endcase
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [19:0] imm;
    logic [31:0] w;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 31));
    imm = 20'($urandom());
    w   = 32'($urandom());
    case ($urandom_range(0, 9))
      0, 1: return {imm, rd, 7'b0110111};
      2, 3: return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
      4, 5: return {7'd0, rs2, rs1, 3'd1, rd, 7'b0010011};
      6, 7: return {7'd0, rs2, rs1, 3'd6, rd, 7'b0110011};
      8: begin
        case ($urandom_range(0, 2))
          0: return 32'h0000_0073;
          1: return {7'b0100000, rs2, rs1, 3'd0, rd, 7'b0110011};
          default: return {7'b0100000, rs2, rs1, 3'd1, rd, 7'b0010011};
        endcase
      end
      default: return w;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr, srca, srcb, opcode, ret;
    logic [4:0]  shamt, addr;
    logic        we, ill, chkdata;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic s, v;
    logic [31:0] w;

    tbl[0] = '{32'h123450B7, 32'h0,        32'h00012345, 32'h12005037, 32'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h00001137, 32'h0,        32'h00000001, 32'h00001037, 32'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h002081B3, 32'h12345000, 32'h00001000, 32'h00000033, 32'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'h0011E233, 32'h12346000, 32'h12345000, 32'h00006033, 32'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h00709293, 32'h12345000, 32'h0,        32'h00001013, 32'd4, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{32'h00108033, 32'h12345000, 32'h12345000, 32'h00000033, 32'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{32'h00506333, 32'h0,        32'h1A280000, 32'h00006033, 32'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{32'h00000073, 32'h0,        32'h0,        32'h0,        32'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};

    resetn = 1'b0; instr = 32'd0; instr_vld = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_srcA", alu_srcA, 32'd0);
    chk("rst_opcode", alu_opcode, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      instr = tbl[i].instr; instr_vld = 1'b1; stall = 1'b0;
      @(posedge clk);
      #1;
      if (tbl[i].chkdata) begin
        chk($sformatf("vec%0d_srcA", i), alu_srcA, tbl[i].srca);
        chk($sformatf("vec%0d_srcB", i), alu_srcB, tbl[i].srcb);
        chk($sformatf("vec%0d_shamt", i), {27'd0, alu_shamt}, {27'd0, tbl[i].shamt});
        chk($sformatf("vec%0d_opcode", i), alu_opcode, tbl[i].opcode);
        chk($sformatf("vec%0d_wb_addr", i), {27'd0, wb_addr}, {27'd0, tbl[i].addr});
      end
      chk($sformatf("vec%0d_wb_we", i), {31'd0, wb_we}, {31'd0, tbl[i].we});
      chk($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, tbl[i].ill});
      chk($sformatf("vec%0d_retired", i), retired, tbl[i].ret);
    end

    // Bubble after the illegal op: pulse ends, counter unchanged.
    @(negedge clk);
    instr_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
    chk("ill_retired", retired, 32'd7);

    // LUI x7 in E, then held by stall for three cycles.
    @(negedge clk);
    instr = 32'hABCDE3B7; instr_vld = 1'b1; stall = 1'b0;
    @(posedge clk);
    #1;
    chk("lui7_srcB", alu_srcB, 32'h000ABCDE);
    chk("lui7_wb_we", {31'd0, wb_we}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stall = 1'b1; instr = 32'h00108133; instr_vld = 1'b1;
      #1;
      chk("stall_rdy", {31'd0, instr_rdy}, 32'd0);
      chk("stall_wb_we", {31'd0, wb_we}, 32'd0);
      chk("stall_srcB", alu_srcB, 32'h000ABCDE);
      chk("stall_wb_addr", {27'd0, wb_addr}, 32'd7);
      chk("stall_retired", retired, 32'd7);
    end

    // Asynchronous reset in the middle of the stall.
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_srcA", alu_srcA, 32'd0);
    chk("arst_srcB", alu_srcB, 32'd0);
    chk("arst_shamt", {27'd0, alu_shamt}, 32'd0);
    chk("arst_opcode", alu_opcode, 32'd0);
    chk("arst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("arst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("arst_retired", retired, 32'd0);
    chk("arst_illegal", {31'd0, illegal}, 32'd0);

    // OR x8,x1,x7 after reset: both sources must read as cleared.
    @(negedge clk);
    resetn = 1'b1; stall = 1'b0; instr = 32'h0070E433; instr_vld = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_srcA", alu_srcA, 32'd0);
    chk("clr_srcB", alu_srcB, 32'd0);
    chk("clr_wb_addr", {27'd0, wb_addr}, 32'd8);
    chk("clr_retired", retired, 32'd0);
    @(negedge clk);
    instr_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_retired2", retired, 32'd1);

    // Randomized traffic against the reference model.
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    m_ret = 32'd1; m_ill = 1'b0; pend.valid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      s = ($urandom_range(0, 4) == 0);
      v = ($urandom_range(0, 3) != 0);
      w = gen_instr();
      stall = s; instr_vld = v; instr = w;
      #1;
      chk("rnd_rdy", {31'd0, instr_rdy}, {31'd0, ~s});
      chk("rnd_wb_we", {31'd0, wb_we}, {31'd0, pend.valid && pend.rd != 5'd0 && !s});
      chk("rnd_illegal", {31'd0, illegal}, {31'd0, m_ill});
      chk("rnd_retired", retired, m_ret);
      if (pend.valid) begin
        chk("rnd_srcA", alu_srcA, pend.srca);
        chk("rnd_srcB", alu_srcB, pend.srcb);
        chk("rnd_shamt", {27'd0, alu_shamt}, {27'd0, pend.shamt});
        chk("rnd_opcode", alu_opcode, pend.opc);
        chk("rnd_wb_addr", {27'd0, wb_addr}, {27'd0, pend.rd});
        chk("rnd_wb_data", wb_data, pend.result);
      end
      @(posedge clk);
      model_edge(v, s, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nf_alu_issue.md
Name: nf_alu_issue

Overview:
Two-stage decode/issue/writeback front end that feeds the combinational ALU and retires its results into the architectural register file. It accepts RV32I instruction words from fetch over a valid/ready handshake and decodes the supported subset: LUI, ADD, SLLI and OR. It reads operands with forwarding from the execute stage, drives the ALU operand and opcode inputs, and writes the ALU result back.

Parameters:
XLEN, 32, datapath and instruction width
RF_DEPTH, 32, number of architectural registers (x0 hardwired zero)

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  reset, asynchronous, active-low
instr  in  32  instruction word from fetch
instr_vld  in  1  instr is valid this cycle
instr_rdy  out  1  stage accepts instr this cycle (~stall)
stall  in  1  downstream hold; freezes both stages
alu_srcA  out  32  ALU operand A (E-stage)
alu_srcB  out  32  ALU operand B (E-stage)
alu_shamt  out  5  ALU shift amount (E-stage)
alu_opcode  out  32  ALU command word (E-stage)
alu_result  in  32  combinational ALU result for current E-stage op
alu_zero  in  1  ALU flag bit 0
wb_we  out  1  register write strobe (E-stage valid, rd!=0, !stall)
wb_addr  out  5  destination register
wb_data  out  32  write data (= alu_result)
illegal  out  1  one-cycle pulse: unsupported instruction accepted
retired  out  32  retired-instruction counter

Behaviour:
- Handshake: transfer when instr_vld & instr_rdy; instr_rdy = ~stall. With stall=1, D and E registers, counter and regfile hold.
- D stage (combinational on accepted instr): decode opcode/funct3/funct7. Match LUI (0110111), ADD (0110011/000/0000000), SLLI (0010011/001/0000000), OR (0110011/110/0000000). Anything else -> illegal pulses next cycle; no E entry, no writeback.
- Operand read: rs1/rs2 from regfile. x0 reads 0. If E valid and E.rd==rs and rs!=0, forward alu_result (same cycle, combinational).
- E register loads on accept: valid, rd, srcA=rs1val, srcB per op (LUI: {12'b0,instr[31:12]}; ADD/OR: rs2val; SLLI: 0), shamt=instr[24:20] for SLLI else 0, opcode = instr with rd/rs1/rs2 fields (bits 24:15, 11:7) zeroed. SLLI shamt is carried separately on alu_shamt.
- Without accept and without stall: E.valid clears (bubble).
- Latency: accepted at edge N -> ALU ops visible after N -> regfile written at edge N+1; dependent instruction issued at N+1 sees forwarded value.
- Writeback: wb_we = E.valid & E.rd!=0 & ~stall. Writes to x0 are ignored.
- retired increments by 1 per E-stage completion (E.valid & ~stall), wraps 0xFFFF_FFFF -> 0. Illegal instructions do not count.
- Reset (async, any time): E.valid=0, illegal=0, retired=0, regfile all 0. alu_srcA/srcB/shamt/opcode=0, wb_we=0, wb_addr=0. An in-flight op is discarded.
- alu_zero: registered into E-side status only; no effect on control in this subset.

Decomposition:
- Package nf_alu_pkg: RV opcode/funct constants; ALU command match patterns; the decoded-op enum (OP_LUI, OP_ADD, OP_SLLI, OP_OR, OP_ILL); the E-stage struct (valid, rd, srcA, srcB, shamt, opcode).
- Sub-module nf_reg_file: 2 async read ports, 1 sync write port, x0 hardwired, async-active-low clear.

Test Plan:
- Reset then LUI x1,0x12345 -> alu_srcB=0x00012345, wb_we=1, wb_addr=1, regfile x1 = ALU result one cycle later; retired=1.
- Back-to-back ADD x3,x1,x2 then OR x4,x3,x1 -> second op's alu_srcA equals forwarded alu_result of first (no bubble); retired=2.
- SLLI x5,x1,7 -> alu_shamt=7, alu_srcB=0, opcode bits 24:15 and 11:7 zero.
- ADD x0,x1,x1 -> wb_we=0; later read of x0 yields srcA=0.
- Instruction 0x00000073 (ECALL) -> illegal pulse 1 cycle, no wb_we, retired unchanged.
- stall=1 for 3 cycles with op in E -> instr_rdy=0, outputs/regfile/retired frozen. Assert resetn=0 mid-stall -> all outputs 0 immediately, regfile cleared.
